// File: rtl/sobel_window_gen_pkg.sv
// Shared definitions for the sobel window generator: pixel width default,
// stream/flush state encoding and a constant ceiling-log2 helper.
package sobel_window_gen_pkg;

    localparam int PIX_W_DEF = 8;

    typedef enum logic {
        STREAM = 1'b0,
        FLUSH  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result = 0;
        int rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two-line history buffer: one word {older line, newer line} per column,
// read combinationally and rewritten at the same address in the same cycle.
module sobel_line_buf #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to zero-padded 3x3 windows, one per pixel, followed by
// an IMG_W+1 push flush that drains the last row of windows.
module sobel_window_gen
    import sobel_window_gen_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int IMG_W = 512,
    parameter int IMG_H = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PIX_W-1:0]        pix_in,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic [PIX_W-1:0]        p0,
    output logic [PIX_W-1:0]        p1,
    output logic [PIX_W-1:0]        p2,
    output logic [PIX_W-1:0]        p3,
    output logic [PIX_W-1:0]        p4,
    output logic [PIX_W-1:0]        p5,
    output logic [PIX_W-1:0]        p6,
    output logic [PIX_W-1:0]        p7,
    output logic [PIX_W-1:0]        p8,
    output logic                    win_valid,
    output logic [clog2(IMG_H)-1:0] win_row,
    output logic [clog2(IMG_W)-1:0] win_col,
    output logic                    frame_done
);

    localparam int ROW_W = clog2(IMG_H);
    localparam int COL_W = clog2(IMG_W);
    localparam int N     = IMG_W * IMG_H;
    localparam int IDX_W = clog2(N + IMG_W + 1);

    localparam logic [IDX_W-1:0] I_LAST_PIX  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] I_LAST      = IDX_W'(N + IMG_W);
    localparam logic [IDX_W-1:0] I_FIRST_WIN = IDX_W'(IMG_W + 1);
    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(IMG_H - 1);

    state_t             state_reg;
    logic               pix_ready_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [COL_W-1:0]   cx_reg;
    logic [ROW_W-1:0]   crow_reg;
    logic [COL_W-1:0]   ccol_reg;
    logic               win_valid_reg;
    logic               frame_done_reg;
    logic [ROW_W-1:0]   win_row_reg;
    logic [COL_W-1:0]   win_col_reg;

    // Two previous columns of the window, index row*2 + col (col 0 = oldest).
    logic [PIX_W-1:0]   hist_reg [6];
    logic [PIX_W-1:0]   out_reg  [9];

    logic               push;
    logic               emit;
    logic [PIX_W-1:0]   pix_eff;
    logic [2*PIX_W-1:0] lb_rd;
    logic [2*PIX_W-1:0] lb_wr;
    logic [PIX_W-1:0]   col_new    [3];
    logic [PIX_W-1:0]   win_next   [9];
    logic [PIX_W-1:0]   win_masked [9];

    assign push    = (state_reg == FLUSH) || (pix_valid && pix_ready_reg);
    assign pix_eff = (state_reg == FLUSH) ? '0 : pix_in;
    assign emit    = push && (idx_reg >= I_FIRST_WIN);

    assign col_new[0] = lb_rd[2*PIX_W-1:PIX_W];
    assign col_new[1] = lb_rd[PIX_W-1:0];
    assign col_new[2] = pix_eff;
    assign lb_wr      = {lb_rd[PIX_W-1:0], pix_eff};

    sobel_line_buf #(
        .DEPTH (IMG_W),
        .AW    (COL_W),
        .DW    (2 * PIX_W)
    ) u_line_buf (
        .clk     (clk),
        .addr    (cx_reg),
        .we      (push),
        .wr_data (lb_wr),
        .rd_data (lb_rd)
    );

    // Border taps come from the neighbouring row/line or stale RAM; force them to zero.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_tap
            localparam int R = gi / 3;
            localparam int C = gi % 3;
            logic kill;
            if (C == 2) begin : g_new
                assign win_next[gi] = col_new[R];
            end else begin : g_hist
                assign win_next[gi] = hist_reg[R*2 + C];
            end
            assign kill = ((C == 0) && (ccol_reg == '0))
                       || ((C == 2) && (ccol_reg == COL_LAST))
                       || ((R == 0) && (crow_reg == '0))
                       || ((R == 2) && (crow_reg == ROW_LAST));
            assign win_masked[gi] = kill ? '0 : win_next[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 6; r++) hist_reg[r] <= '0;
            for (int j = 0; j < 9; j++) out_reg[j] <= '0;
        end else begin
            if (push) begin
                for (int r = 0; r < 3; r++) begin
                    hist_reg[r*2]     <= hist_reg[r*2 + 1];
                    hist_reg[r*2 + 1] <= col_new[r];
                end
            end
            if (emit) begin
                for (int j = 0; j < 9; j++) out_reg[j] <= win_masked[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= STREAM;
            pix_ready_reg  <= 1'b1;
            idx_reg        <= '0;
            cx_reg         <= '0;
            crow_reg       <= '0;
            ccol_reg       <= '0;
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            win_row_reg    <= '0;
            win_col_reg    <= '0;
        end else begin
            win_valid_reg  <= emit;
            frame_done_reg <= 1'b0;
            if (emit) begin
                win_row_reg <= crow_reg;
                win_col_reg <= ccol_reg;
                if (ccol_reg == COL_LAST) begin
                    ccol_reg <= '0;
                    crow_reg <= (crow_reg == ROW_LAST) ? '0 : crow_reg + 1'b1;
                end else begin
                    ccol_reg <= ccol_reg + 1'b1;
                end
            end
            if (push) begin
                idx_reg <= idx_reg + 1'b1;
                cx_reg  <= (cx_reg == COL_LAST) ? '0 : cx_reg + 1'b1;
                case (state_reg)
                    STREAM: begin
                        if (idx_reg == I_LAST_PIX) begin
                            state_reg     <= FLUSH;
                            pix_ready_reg <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        if (idx_reg == I_LAST) begin
                            state_reg      <= STREAM;
                            pix_ready_reg  <= 1'b1;
                            idx_reg        <= '0;
                            cx_reg         <= '0;
                            frame_done_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= STREAM;
                endcase
            end
        end
    end

    assign pix_ready  = pix_ready_reg;
    assign win_valid  = win_valid_reg;
    assign frame_done = frame_done_reg;
    assign win_row    = win_row_reg;
    assign win_col    = win_col_reg;
    assign p0 = out_reg[0];
    assign p1 = out_reg[1];
    assign p2 = out_reg[2];
    assign p3 = out_reg[3];
    assign p4 = out_reg[4];
    assign p5 = out_reg[5];
    assign p6 = out_reg[6];
    assign p7 = out_reg[7];
    assign p8 = out_reg[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Randomized bench for sobel_window_gen on a 4x4 image against a zero-padded
// 3x3 software model; one line printed per window.
module tb_sobel_window_gen;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pix_in = '0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
    logic       win_valid;
    logic [1:0] win_row;
    logic [1:0] win_col;
    logic       frame_done;

    always #5 clk = ~clk;

    sobel_window_gen #(
        .PIX_W (8),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .p0         (p0),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p4         (p4),
        .p5         (p5),
        .p6         (p6),
        .p7         (p7),
        .p8         (p8),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int frames   = 0;
    int img [W*H];
    logic [76:0] exp_q [$];

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected window packed as {p0..p8, row, col, frame_done}.
    function automatic logic [76:0] model_win(input int r, input int c);
        logic [71:0] w = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                int rr = r + dr;
                int cc = c + dc;
                int v  = (rr >= 0 && rr < H && cc >= 0 && cc < W) ? img[rr*W + cc] : 0;
                w = {w[63:0], v[7:0]};
            end
        end
        return {w, r[1:0], c[1:0], (r == H-1 && c == W-1)};
    endfunction

    task automatic send_pixel(input logic [7:0] v, input int gap);
        int   guard = 0;
        logic rdy;
        while (int'($urandom_range(99)) < gap) begin
            pix_valid = 1'b0;
            @(posedge clk); #1;
        end
        pix_valid = 1'b1;
        pix_in    = v;
        do begin
            @(negedge clk);
            rdy = pix_ready;
            @(posedge clk); #1;
            guard++;
        end while (!rdy && guard < 50);
        if (!rdy) check_val("accept_timeout", 0, 1);
        pix_valid = 1'b0;
    endtask

    // kind 0: base+i ramp, kind 1: random pixels; npix < W*H aborts the frame early.
    task automatic send_frame(input int kind, input int base, input int gap, input int npix);
        for (int i = 0; i < W*H; i++) img[i] = (kind == 0) ? base + i : int'($urandom_range(255));
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) exp_q.push_back(model_win(r, c));
        for (int i = 0; i < npix; i++) send_pixel(8'(img[i]), gap);
    endtask

    initial begin : monitor
        int   acc = 0;
        int   win_in_frame = 0;
        int   rdy_low = 0;
        logic xfer_prev = 1'b0;
        logic [76:0] got;
        logic [76:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                acc = 0;
                win_in_frame = 0;
                rdy_low = 0;
                xfer_prev = 1'b0;
            end else begin
                if (xfer_prev) acc++;
                got = {p0, p1, p2, p3, p4, p5, p6, p7, p8, win_row, win_col, frame_done};
                if (win_valid) begin
                    $display("win (%0d,%0d) = %0d %0d %0d %0d %0d %0d %0d %0d %0d fd=%0d",
                             win_row, win_col, p0, p1, p2, p3, p4, p5, p6, p7, p8, frame_done);
                    if (win_in_frame == 0) check_val("first_win_latency", acc, 6);
                    if (exp_q.size() == 0) begin
                        check_val("spurious_window", got, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("window", got, e);
                    end
                    if (frames < 2) begin
                        case ({win_row, win_col})
                            4'b0000: check_val("ref_win_0_0", got[76:5], 72'h00_00_00_00_01_02_00_05_06);
                            4'b0101: check_val("ref_win_1_1", got[76:5], 72'h01_02_03_05_06_07_09_0a_0b);
                            4'b0111: check_val("ref_win_1_3", got[76:5], 72'h03_04_00_07_08_00_0b_0c_00);
                            4'b1111: check_val("ref_win_3_3", got[76:5], 72'h0b_0c_00_0f_10_00_00_00_00);
                            default: ;
                        endcase
                    end
                    win_in_frame++;
                    if (frame_done) begin
                        check_val("frame_window_count", win_in_frame, 16);
                        frames++;
                        win_in_frame = 0;
                        acc = 0;
                    end
                end else if (frame_done) begin
                    check_val("frame_done_without_valid", 1, 0);
                end
                if (!pix_ready) rdy_low++;
                else if (rdy_low != 0) begin
                    check_val("flush_ready_low_cycles", rdy_low, 5);
                    rdy_low = 0;
                end
                xfer_prev = pix_valid && pix_ready;
            end
        end
    end

    initial begin : driver
        int guard;
        rst = 1'b1;
        @(negedge clk);
        check_val("reset_state", {p0, p1, p2, p3, p4, p5, p6, p7, p8, win_valid, frame_done,
                                  win_row, win_col, pix_ready}, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        send_frame(0, 1, 0, 16);
        send_frame(0, 1, 50, 16);
        send_frame(1, 0, 50, 16);
        send_frame(1, 0, 30, 7);

        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_frame_reset", {p0, p1, p2, p3, p4, p5, p6, p7, p8, win_valid, frame_done,
                                      win_row, win_col, pix_ready}, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        send_frame(0, 100, 50, 16);
        send_frame(1, 0, 0, 16);

        guard = 0;
        while ((exp_q.size() != 0 || !pix_ready) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check_val("drain_queue_empty", exp_q.size(), 0);
        check_val("frames_done", frames, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
